// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and the bridge state machine encoding.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDAT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of an AHB address phase: slave index, region hit,
// and whether the size/alignment pair is legal for the data bus width.
module apb_addr_decode #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                NSLV      = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                SEL_LSB   = 24,
   localparam int               IDX_W     = (NSLV > 1) ? $clog2(NSLV) : 1
) (
   input  logic [ADDR_W-1:0] haddr,
   input  logic [2:0]        hsize,
   output logic [IDX_W-1:0]  idx,
   output logic              in_range,
   output logic              align_ok
);

   localparam int SIZE_MAX = $clog2(DATA_W / 8);
   // One extra bit so a region ending at the top of the address map does not wrap.
   localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + ((ADDR_W + 1)'(NSLV) << SEL_LSB);

   logic aligned;

   generate
      if (NSLV > 1) begin : g_multi
         assign idx = haddr[SEL_LSB +: IDX_W];
      end else begin : g_single
         assign idx = '0;
      end
   endgenerate

   always_comb begin
      case (hsize)
         3'd1:    aligned = ~haddr[0];
         3'd2:    aligned = (haddr[1:0] == 2'b00);
         3'd3:    aligned = (haddr[2:0] == 3'b000);
         default: aligned = 1'b1;
      endcase
   end

   assign in_range = (haddr >= BASE_ADDR) && ({1'b0, haddr} < LIMIT);
   assign align_ok = (hsize <= 3'(SIZE_MAX)) && aligned;

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite slave to APB3 master bridge with one-hot PSEL fan-out, wait states,
// slave/decode error mapping onto a two-cycle AHB ERROR, and optional PREADY timeout.
module ahb_apb_bridge_p
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                NSLV      = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                SEL_LSB   = 24,
   parameter int                TIMEOUT   = 0
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADYin,
   output logic              HREADYout,
   output logic [1:0]        HRESP,
   output logic [DATA_W-1:0] HRDATA,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PWRITE,
   output logic [NSLV-1:0]   PSEL,
   output logic              PENABLE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt, dec_idx;
   logic             in_range, align_ok, accept, timeout_hit;
   logic [NSLV-1:0]  psel_nxt;
   logic [15:0]      tcnt;

   apb_addr_decode #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NSLV      (NSLV),
      .BASE_ADDR (BASE_ADDR),
      .SEL_LSB   (SEL_LSB)
   ) u_decode (
      .haddr    (HADDR),
      .hsize    (HSIZE),
      .idx      (dec_idx),
      .in_range (in_range),
      .align_ok (align_ok)
   );

   assign accept = HREADYin && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) &&
                   (state == ST_IDLE || state == ST_ERR2);

   // Fires on the TIMEOUT-th consecutive PREADY-low cycle of ACCESS.
   assign timeout_hit = (TIMEOUT != 0) && !PREADY && (tcnt == 16'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx_q;
      psel_nxt  = '0;
      case (state)
         ST_IDLE, ST_ERR2: begin
            state_nxt = ST_IDLE;
            if (accept) begin
               idx_nxt = dec_idx;
               if (!(in_range && align_ok)) state_nxt = ST_ERR1;
               else if (HWRITE)             state_nxt = ST_WDAT;
               else                         state_nxt = ST_SETUP;
            end
         end
         ST_WDAT:  state_nxt = ST_SETUP;
         ST_SETUP: state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY)           state_nxt = PSLVERR ? ST_ERR1 : ST_IDLE;
            else if (timeout_hit) state_nxt = ST_ERR1;
         end
         ST_ERR1:  state_nxt = ST_ERR2;
         default:  state_nxt = ST_IDLE;
      endcase
      for (int i = 0; i < NSLV; i++) begin
         psel_nxt[i] = (state_nxt == ST_SETUP || state_nxt == ST_ACCESS) &&
                       (idx_nxt == IDX_W'(i));
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         HREADYout <= 1'b1;
         HRESP     <= HRESP_OKAY;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
      end else begin
         state     <= state_nxt;
         HREADYout <= (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
         HRESP     <= (state_nxt == ST_ERR1 || state_nxt == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
         PSEL      <= psel_nxt;
         PENABLE   <= (state_nxt == ST_ACCESS);
      end
   end

   // Capture registers: APB address/control only move for transfers that reach the bus.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         idx_q  <= '0;
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         HRDATA <= '0;
         tcnt   <= '0;
      end else begin
         if (accept) idx_q <= dec_idx;
         if (accept && in_range && align_ok) begin
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
         end
         if (state == ST_WDAT) PWDATA <= HWDATA;
         if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
         if (state != ST_ACCESS) tcnt <= '0;
         else if (!PREADY)       tcnt <= tcnt + 16'd1;
      end
   end

endmodule

// File: doc/ahb_apb_bridge_p.md
# ahb_apb_bridge_p

Parametrised AHB-Lite to APB3 bridge: one AHB slave port, one APB master port fanning out to `NSLV` peripherals through one-hot `PSEL`. It succeeds the fixed 3-slave, 32-bit bridge and adds:
- configurable address/data width and slave count
- `PREADY` wait states and `PSLVERR` mapped to a two-cycle AHB ERROR
- decode/alignment error detection
- an optional `PREADY` timeout

## Interface

Parameters:

- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (32 or 64)
- `NSLV`, 4, number of APB slaves (1..16)
- `BASE_ADDR`, 32'h8000_0000, start of bridge region
- `SEL_LSB`, 24, log2 of per-slave region size; slave index = `HADDR[SEL_LSB +: $clog2(NSLV)]`
- `TIMEOUT`, 0, max `PREADY`-low cycles in ACCESS before abort (0 = disabled; counter 16 bits)

Ports:

- `HCLK` in 1: single clock
- `HRESETn` in 1: synchronous, active-low reset
- `HADDR` in `ADDR_W`: AHB address
- `HTRANS` in 2: AHB transfer type
- `HWRITE` in 1: AHB write
- `HSIZE` in 3: AHB transfer size
- `HWDATA` in `DATA_W`: AHB write data
- `HREADYin` in 1: AHB ready in
- `HREADYout` out 1: registered ready
- `HRESP` out 2: 00 OKAY, 01 ERROR
- `HRDATA` out `DATA_W`: registered read data
- `PADDR` out `ADDR_W`: APB address
- `PWDATA` out `DATA_W`: APB write data
- `PWRITE` out 1: APB write
- `PSEL` out `NSLV`: one-hot select
- `PENABLE` out 1: APB enable
- `PRDATA` in `DATA_W`: shared, externally muxed read data
- `PREADY` in 1: shared slave ready
- `PSLVERR` in 1: shared slave error

## Operation

**Valid transfer.** Sampled in a cycle where `HREADYin`=1, `HTRANS[1]`=1 (NONSEQ/SEQ) and the FSM is in IDLE or ERR2. IDLE/BUSY transfers get zero-wait OKAY. A transfer is in range when `BASE_ADDR` ≤ `HADDR` < `BASE_ADDR + NSLV<<SEL_LSB`.

**Accept edge.** On acceptance, latch `HADDR`, `HWRITE` and the slave index.
- Decode error: out of range, `HSIZE` > log2(`DATA_W`/8), or `HADDR` misaligned to `HSIZE`. Next state is ERR1 and no APB access occurs.
- Otherwise next state is WDAT for a write, SETUP for a read.

**States:**
- IDLE: `HREADYout`=1, `HRESP`=00, `PSEL`=0, `PENABLE`=0.
- WDAT: capture `HWDATA` into `PWDATA`; `HREADYout`=0. Next SETUP.
- SETUP: `PSEL[idx]`=1, `PENABLE`=0, `PADDR`/`PWRITE` valid; `HREADYout`=0. Next ACCESS.
- ACCESS: `PSEL`=1, `PENABLE`=1, `HREADYout`=0.
  - `PREADY`=1 and `PSLVERR`=0: go to IDLE; load `HRDATA`←`PRDATA` on reads.
  - `PREADY`=1 and `PSLVERR`=1: go to ERR1.
  - Timeout counter reaching `TIMEOUT` with `PREADY` still 0: go to ERR1.
- ERR1: `HREADYout`=0, `HRESP`=01, `PSEL`=0, `PENABLE`=0. Next ERR2.
- ERR2: `HREADYout`=1, `HRESP`=01. Accepts a new valid transfer exactly like IDLE; otherwise next IDLE.

**Output holding.** `PADDR`, `PWDATA`, `PWRITE` and `HRDATA` hold their last values outside active states. `HRDATA` is unchanged after writes and errors.

**Reset.** `HRESETn`=0 at any edge forces IDLE, including mid-transfer. All outputs go to 0 except `HREADYout`=1; the timeout counter clears.

## Timing

**Latency.** `HREADYout`-low cycles after the accept edge, with `PREADY` tied high:
- write: 3 (WDAT, SETUP, ACCESS)
- read: 2 (SETUP, ACCESS)

Each `PREADY`-low cycle in ACCESS adds one cycle.

**Back-to-back.** The completion cycle (IDLE, `HREADYout`=1) can accept the next address phase, so there are no idle bubbles beyond the latencies above.

**Error response.** Always exactly two cycles: ERR1 then ERR2.

**Registered signals.** All outputs are registered. `PREADY`, `PSLVERR` and `PRDATA` are sampled only in ACCESS.

**Timeout counter.** Clears on entry to ACCESS and increments each `PREADY`-low cycle. With `TIMEOUT`=N the abort happens on the Nth consecutive low cycle; `PSEL` deasserts in ERR1.

**Ignored inputs.** `HTRANS` changes during wait states are ignored.

## Structure

- Package `ahb_apb_pkg` holds:
  - `HTRANS` codes (IDLE/BUSY/NONSEQ/SEQ)
  - `HRESP` codes
  - the state enum (IDLE, WDAT, SETUP, ACCESS, ERR1, ERR2)
- Sub-module `apb_addr_decode` (combinational) computes slave index, in-range and alignment-valid from `HADDR`/`HSIZE` and the parameters.
- The FSM, capture registers and timeout counter live in the top module.

## Test plan

- Write 0x8100_0010 ← 0xDEAD_BEEF, `PREADY`=1 → `PSEL`=0010, `PWDATA`=0xDEADBEEF in SETUP/ACCESS, `HREADYout` low 3 cycles, `HRESP`=00.
- Read 0x8300_0004 with `PREADY` low 2 cycles, `PRDATA`=0x1234_5678 → `PSEL`=1000, `HREADYout` low 4 cycles, `HRDATA`=0x12345678 on completion.
- Read 0x9000_0000 (out of range) → no `PSEL`; ERR1 (`HREADYout`=0, `HRESP`=01) then ERR2 (`HREADYout`=1, `HRESP`=01). Repeat with `HSIZE`=2 at `HADDR`=0x8000_0002 → same ERROR.
- Write with `PSLVERR`=1 at `PREADY` → two-cycle ERROR, `PSEL` drops in ERR1. A NONSEQ presented in ERR2 is accepted.
- `TIMEOUT`=4, `PREADY` stuck 0 → ERR1 entered after 4 ACCESS cycles, then normal operation resumes.
- `HRESETn`=0 during ACCESS → next cycle `PSEL`=0, `PENABLE`=0, `HREADYout`=1, `HRESP`=00. Back-to-back reads to slaves 0 and 1 → second accepted in the first's completion cycle.
